div_iterative: RTL and testbench

Sequential 32-bit signed integer divider: the divide half of the processor's multdiv unit, the iterative counterpart to the single-cycle bitwise ALU datapath. It accepts a start pulse with dividend and divisor, produces one quotient bit per cycle via restoring shift-subtract, and signals completion with a one-cycle ready pulse. The processor stalls on it through the execute stage until `data_resultRDY` is asserted.

---
 rtl/div_iterative_if.sv | 21 ++
 rtl/div_iterative.sv | 95 +++++++++
 tb/tb_div_iterative.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/div_iterative_if.sv
// Handshake/operand bundle for the iterative divider: the requester drives
// the start pulse and operands, the divider returns the quotient and status.
interface div_iterative_if #(parameter int WIDTH = 32);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_iterative.sv
// 32-bit signed restoring divider: one quotient bit per cycle, fixed
// 33-cycle start-to-ready latency including divide-by-zero and overflow.
module div_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  div_iterative_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q, quo_q, absb_q, result_q;
  logic [4:0]       cnt_q;
  logic             qsign_q, dz_q, ovf_q, exc_q, rdy_q;

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_d, quo_d, absa, absb;
  logic             dz, ovf;

  always_comb begin
    absa = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    absb = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    dz   = (bus.data_operandB == '0);
    ovf  = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.data_operandB == '1);
    // Remainder stays below |B| <= 2^31, so 32 stored bits plus the shifted-in
    // quotient MSB form the full 33-bit trial subtraction.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, absb_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      absb_q   <= '0;
      cnt_q    <= '0;
      qsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_DIV) begin
        state_q <= RUN;
        rem_q   <= '0;
        quo_q   <= absa;
        absb_q  <= absb;
        cnt_q   <= '0;
        qsign_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        dz_q    <= dz;
        ovf_q   <= ovf;
      end else begin
        case (state_q)
          RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= FIX;
          end
          FIX: begin
            if (dz_q) begin
              result_q <= '0;
              exc_q    <= 1'b1;
            end else if (ovf_q) begin
              result_q <= {1'b1, {(WIDTH-1){1'b0}}};
              exc_q    <= 1'b1;
            end else begin
              result_q <= qsign_q ? -quo_q : quo_q;
              exc_q    <= 1'b0;
            end
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == RUN) || (state_q == FIX);
endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: cycle-level behavioural model plus
// directed literal cases and randomized operands.
module tb_div_iterative;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  div_iterative_if #(.WIDTH(32)) bus();
  div_iterative #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {exception, quotient} straight from the arithmetic definition
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    return {1'b0, q[31:0]};
  endfunction

  // Timing model: an accepted start makes the result visible 33 edges later.
  logic        model_on = 1'b0;
  logic        m_active = 1'b0;
  int          m_cnt = 0;
  logic [32:0] m_pend = '0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;
  logic        m_rdy = 1'b0;

  always @(posedge clock) begin
    model_on = 1'b1;
    m_rdy = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_res = '0;
      m_exc = 1'b0;
    end else if (bus.ctrl_DIV) begin
      m_pend = ref_div(bus.data_operandA, bus.data_operandB);
      m_active = 1'b1;
      m_cnt = 0;
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == 33) begin
        m_res = m_pend[31:0];
        m_exc = m_pend[32];
        m_rdy = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("model_rdy", 32'(bus.data_resultRDY), 32'(m_rdy));
      check("model_busy", 32'(bus.busy), 32'(m_active));
      check("model_result", bus.data_result, m_res);
      check("model_exc", 32'(bus.data_exception), 32'(m_exc));
    end
  end

  // Caller is at a negedge; start edge is the next posedge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_DIV = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string nm, output int lat);
    int k = 1;
    while (!bus.data_resultRDY && k < 45) begin
      @(negedge clock);
      k++;
    end
    lat = k - 1;
    if (!bus.data_resultRDY) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no ready expected ready within 44 cycles", nm);
    end
  endtask

  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
    int lat;
    start(a, b);
    wait_rdy(nm, lat);
    check({nm, "_lat"}, lat, 32'd33);
    check({nm, "_res"}, bus.data_result, er);
    check({nm, "_exc"}, 32'(bus.data_exception), 32'(ee));
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    logic [32:0] r;
    bit seen;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(negedge clock);
    check("rst_result", bus.data_result, 32'h0);
    check("rst_exc", 32'(bus.data_exception), 32'h0);
    check("rst_rdy", 32'(bus.data_resultRDY), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    run_div("p100_7",   32'd100,        32'd7,        32'h0000_000E, 1'b0);
    run_div("m100_7",   -32'sd100,      32'd7,        32'hFFFF_FFF2, 1'b0);
    run_div("p100_m7",  32'd100,        -32'sd7,      32'hFFFF_FFF2, 1'b0);
    run_div("div0",     32'd7,          32'd0,        32'h0,         1'b1);
    run_div("ovf",      32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_div("min_1",    32'h8000_0000,  32'd1,        32'h8000_0000, 1'b0);
    run_div("max_max",  32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'd1,        1'b0);
    run_div("zero_5",   32'd0,          32'd5,        32'd0,         1'b0);
    run_div("m100_m7",  -32'sd100,      -32'sd7,      32'd14,        1'b0);

    // Reset mid-operation clears the held result and suppresses the ready pulse
    start(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_result", bus.data_result, 32'h0);
    check("midrst_exc", 32'(bus.data_exception), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_rdy", 32'(bus.data_resultRDY), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) seen = 1'b1;
    end
    check("midrst_no_rdy", 32'(seen), 32'h0);

    // Abort and restart, then back-to-back start in the ready cycle
    start(32'd1000, 32'd3);
    repeat (4) @(negedge clock);
    start(32'd9, 32'd3);
    wait_rdy("restart", lat);
    check("restart_lat", lat, 32'd33);
    check("restart_res", bus.data_result, 32'd3);
    start(32'd8, 32'd2);
    wait_rdy("b2b", lat);
    check("b2b_lat", lat, 32'd33);
    check("b2b_res", bus.data_result, 32'd4);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = $urandom_range(1, 20); end
        2: begin a = $urandom; b = 32'h0; end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = 32'h8000_0000; b = $urandom; end
        default: begin a = 32'($signed($urandom_range(0, 2000)) - 1000);
                       b = 32'($signed($urandom_range(0, 40)) - 20); end
      endcase
      r = ref_div(a, b);
      start(a, b);
      wait_rdy("rand", lat);
      check("rand_lat", lat, 32'd33);
      check("rand_res", bus.data_result, r[31:0]);
      check("rand_exc", 32'(bus.data_exception), 32'(r[32]));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
